// File: rtl/twiddle_rotator.sv
// Inter-stage twiddle multiplier for a radix-2^2 SDF FFT pipeline.
// Derives the twiddle exponent from a sample counter, addresses an external registered ROM, and rotates each sample.
module twiddle_rotator #(
    parameter int WIDTH    = 8,
    parameter int TW_WIDTH = 8,
    parameter int N        = 16,
    parameter int AW       = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic signed [WIDTH-1:0]    in_re,
    input  logic signed [WIDTH-1:0]    in_im,
    output logic        [AW-1:0]       tw_addr,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    output logic                       out_valid,
    output logic                       out_sof,
    output logic signed [WIDTH-1:0]    out_re,
    output logic signed [WIDTH-1:0]    out_im
);

    localparam int PW = WIDTH + TW_WIDTH;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (TW_WIDTH - 2));
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = (v + RND) >>> (TW_WIDTH - 1);
        if (r > SMAX)
            return SMAX[WIDTH-1:0];
        else if (r < SMIN)
            return SMIN[WIDTH-1:0];
        else
            return r[WIDTH-1:0];
    endfunction

    // ---------------- sample counter and twiddle exponent ----------------
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_q;
    logic [AW-1:0] w_qs;
    logic [AW-1:0] w_k;
    logic [AW-1:0] w_e;

    assign w_idx = in_sof ? '0 : r_cnt;
    assign w_q   = w_idx[AW-1 -: 2];
    // quadrant order {0,2,1,3} is the bit-reverse of the 2-bit quadrant index
    assign w_qs    = {{(AW-2){1'b0}}, w_q[0], w_q[1]};
    assign w_k     = {2'b00, w_idx[AW-3:0]};
    assign w_e     = w_qs * w_k;
    assign tw_addr = in_valid ? w_e : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (in_valid)
            r_cnt <= w_idx + AW'(1);
    end

    // ---------------- S1: capture sample alongside ROM lookup ----------------
    logic                    r1_valid, r1_sof, r1_byp;
    logic signed [WIDTH-1:0] r1_re, r1_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sof   <= 1'b0;
            r1_byp   <= 1'b0;
            r1_re    <= '0;
            r1_im    <= '0;
        end else begin
            r1_valid <= in_valid;
            r1_sof   <= in_valid & in_sof;
            if (in_valid) begin
                r1_byp <= (w_e == '0);
                r1_re  <= in_re;
                r1_im  <= in_im;
            end
        end
    end

    // ---------------- S2: partial products ----------------
    logic signed [PW-1:0] w_ar, w_ai, w_tr, w_ti;
    assign w_ar = PW'(r1_re);
    assign w_ai = PW'(r1_im);
    assign w_tr = PW'(tw_re);
    assign w_ti = PW'(tw_im);

    logic                    r2_valid, r2_sof, r2_byp;
    logic signed [WIDTH-1:0] r2_re, r2_im;
    logic signed [PW-1:0]    r2_p_rr, r2_p_ii, r2_p_ri, r2_p_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_sof   <= 1'b0;
            r2_byp   <= 1'b0;
            r2_re    <= '0;
            r2_im    <= '0;
            r2_p_rr  <= '0;
            r2_p_ii  <= '0;
            r2_p_ri  <= '0;
            r2_p_ir  <= '0;
        end else begin
            r2_valid <= r1_valid;
            r2_sof   <= r1_valid & r1_sof;
            if (r1_valid) begin
                r2_byp  <= r1_byp;
                r2_re   <= r1_re;
                r2_im   <= r1_im;
                r2_p_rr <= w_ar * w_tr;
                r2_p_ii <= w_ai * w_ti;
                r2_p_ri <= w_ar * w_ti;
                r2_p_ir <= w_ai * w_tr;
            end
        end
    end

    // ---------------- S3: combine, round, saturate ----------------
    logic signed [SW-1:0]    w_sum_re, w_sum_im;
    logic signed [WIDTH-1:0] w_rot_re, w_rot_im;

    assign w_sum_re = SW'(r2_p_rr) - SW'(r2_p_ii);
    assign w_sum_im = SW'(r2_p_ri) + SW'(r2_p_ir);
    assign w_rot_re = round_sat(w_sum_re);
    assign w_rot_im = round_sat(w_sum_im);

    // W^0 = 1 has no Q1 encoding, so e==0 samples skip the multiplier entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= r2_valid;
            out_sof   <= r2_valid & r2_sof;
            if (r2_valid) begin
                out_re <= r2_byp ? r2_re : w_rot_re;
                out_im <= r2_byp ? r2_im : w_rot_im;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator.sv
// Directed-vector bench for twiddle_rotator with a behavioural registered twiddle ROM (N=16, Q1.7).
module tb_twiddle_rotator;

    localparam int WIDTH    = 8;
    localparam int TW_WIDTH = 8;
    localparam int N        = 16;
    localparam int AW       = 4;

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_sof   = 1'b0;
    logic signed [WIDTH-1:0] in_re    = '0;
    logic signed [WIDTH-1:0] in_im    = '0;
    logic        [AW-1:0]    tw_addr;
    logic signed [TW_WIDTH-1:0] tw_re = '0;
    logic signed [TW_WIDTH-1:0] tw_im = '0;
    logic                    out_valid, out_sof;
    logic signed [WIDTH-1:0] out_re, out_im;

    int n_pass = 0;
    int n_chk  = 0;
    int n_out  = 0;

    always #5 clk = ~clk;

    twiddle_rotator #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .N(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_sof(out_sof), .out_re(out_re), .out_im(out_im)
    );

    // cos / -sin of 2*pi*e/16 in Q1.7
    int rom_re[16] = '{127, 118, 91, 49, 0, -49, -91, -118, -128, -118, -91, -49, 0, 49, 91, 118};
    int rom_im[16] = '{0, -49, -91, -118, -128, -118, -91, -49, 0, 49, 91, 118, 127, 118, 91, 49};

    always @(posedge clk) begin
        tw_re <= 8'(rom_re[tw_addr]);
        tw_im <= 8'(rom_im[tw_addr]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    typedef struct {
        logic sof;
        int   re;
        int   im;
        int   addr;
        int   ore;
        int   oim;
    } vec_t;

    typedef struct {
        int   re;
        int   im;
        logic sof;
    } exp_t;

    exp_t expq[$];
    vec_t tbl[17];

    // in_valid history: after edge E, h2 holds in_valid accepted at E-2
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
        end else begin
            h2 <= h1; h1 <= h0; h0 <= in_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid_timing", int'(out_valid), int'(h2));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("out_extra", int'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk($sformatf("out%0d_re", n_out), int'(out_re), e.re);
                    chk($sformatf("out%0d_im", n_out), int'(out_im), e.im);
                    chk($sformatf("out%0d_sof", n_out), int'(out_sof), int'(e.sof));
                    n_out++;
                end
            end
        end
    end

    task automatic drive(input logic sof, input int re, input int im,
                         input int eaddr, input int ere, input int eim);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = 8'(re);
        in_im    = 8'(im);
        #1 chk("tw_addr", int'(tw_addr), eaddr);
        e.re = ere; e.im = eim; e.sof = sof;
        expq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = 8'($urandom);
        in_im    = 8'($urandom);
        #1 chk("tw_addr_idle", int'(tw_addr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1,  127, -128, 0,  127, -128};
        tbl[1]  = '{1'b0,   -1,    1, 0,   -1,    1};
        tbl[2]  = '{1'b0,    5,    0, 0,    5,    0};
        tbl[3]  = '{1'b0,    0,   -7, 0,    0,   -7};
        tbl[4]  = '{1'b0,   10,  -10, 0,   10,  -10};
        tbl[5]  = '{1'b0,   64,    0, 2,   46,  -45};
        tbl[6]  = '{1'b0,   50,   20, 4,   20,  -50};
        tbl[7]  = '{1'b0,    0,   64, 6,   46,  -45};
        tbl[8]  = '{1'b0,  -50,   60, 0,  -50,   60};
        tbl[9]  = '{1'b0,  100,    0, 1,   92,  -38};
        tbl[10] = '{1'b0, -128, -128, 2, -128,    0};
        tbl[11] = '{1'b0,  127,  127, 3,  127,  -68};
        tbl[12] = '{1'b0,    1,    2, 0,    1,    2};
        tbl[13] = '{1'b0,    0,    0, 3,    0,    0};
        tbl[14] = '{1'b0,   10,    0, 6,   -7,   -7};
        tbl[15] = '{1'b0,    0, -100, 9,   38,   92};
        tbl[16] = '{1'b0,    3,    4, 0,    3,    4};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof",   int'(out_sof),   0);
        chk("rst_out_re",    int'(out_re),    0);
        chk("rst_out_im",    int'(out_im),    0);
        chk("rst_tw_addr",   int'(tw_addr),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // full frame plus wrap
        for (int i = 0; i < 17; i++)
            drive(tbl[i].sof, tbl[i].re, tbl[i].im, tbl[i].addr, tbl[i].ore, tbl[i].oim);
        repeat (4) idle();

        // alternating bubbles
        for (int j = 0; j < 7; j++) begin
            drive(j == 0, tbl[j].re, tbl[j].im, tbl[j].addr, tbl[j].ore, tbl[j].oim);
            idle();
        end
        repeat (3) idle();

        // resync with in_sof at n=9
        for (int j = 0; j < 9; j++)
            drive(j == 0, 0, 0, tbl[j].addr, 0, 0);
        drive(1'b1, 7, -3, 0, 7, -3);
        for (int j = 1; j < 6; j++)
            drive(1'b0, tbl[j].re, tbl[j].im, tbl[j].addr, tbl[j].ore, tbl[j].oim);
        repeat (3) idle();

        // asynchronous reset with samples in flight
        drive(1'b1, 11, 12, 0, 11, 12);
        drive(1'b0, 13, 14, 0, 13, 14);
        drive(1'b0, 15, 16, 0, 15, 16);
        @(posedge clk);
        #1 chk("inflight_out_valid", int'(out_valid), 1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_sof",   int'(out_sof),   0);
        chk("arst_out_re",    int'(out_re),    0);
        chk("arst_out_im",    int'(out_im),    0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++)
            drive(1'b0, tbl[j].re, tbl[j].im, tbl[j].addr, tbl[j].ore, tbl[j].oim);
        repeat (4) idle();

        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
